// File: rtl/tuner_phy_pkg.sv
// Shared tuner PHY types: power-detect FSM state and detect request mode.
package tuner_phy_pkg;

    typedef enum logic [2:0] {
        DETECT_IDLE   = 3'd0,
        DETECT_WAIT   = 3'd1,
        DETECT_ACTIVE = 3'd2,
        DETECT_DONE   = 3'd3
    } tuner_phy_detect_state_e;

    typedef enum logic {
        PWR_READ   = 1'b0,
        PWR_DETECT = 1'b1
    } tuner_phy_detect_if_state_e;

endpackage

// File: rtl/tuner_phy_pwr_avg.sv
// Boxcar accumulator over 2^AVG_LOG2 power samples. The averaged point is presented
// combinationally alongside the sample that completes the group.
module tuner_phy_pwr_avg #(
    parameter int unsigned PWR_W    = 16,
    parameter int unsigned CODE_W   = 10,
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              valid_i,
    input  logic [PWR_W-1:0]  pwr_i,
    input  logic [CODE_W-1:0] code_i,
    output logic              avg_valid_o,
    output logic [PWR_W-1:0]  avg_o,
    output logic [CODE_W-1:0] avg_code_o
);

    localparam int unsigned SUM_W    = PWR_W + AVG_LOG2;
    localparam int unsigned CNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned GRP_LAST = (1 << AVG_LOG2) - 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [SUM_W-1:0] sum_full;
    logic             last;

    assign sum_full = sum_q + SUM_W'(pwr_i);
    assign last     = (cnt_q == CNT_W'(GRP_LAST));

    // Group bookkeeping; a clear drops any partial group
    always_comb begin
        cnt_d = cnt_q;
        sum_d = sum_q;
        if (clr_i) begin
            cnt_d = '0;
            sum_d = '0;
        end else if (valid_i) begin
            if (last) begin
                cnt_d = '0;
                sum_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                sum_d = sum_full;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sum_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sum_q <= sum_d;
        end
    end

    assign avg_valid_o = valid_i && last && !clr_i;
    assign avg_o       = PWR_W'(sum_full >> AVG_LOG2);
    assign avg_code_o  = code_i;

endmodule

// File: rtl/tuner_phy_peak_detect.sv
// Power-detect stage: settles, averages power samples, then returns a single reading
// or the first hysteresis-qualified resonance peak, held until acknowledged.
module tuner_phy_peak_detect
    import tuner_phy_pkg::*;
#(
    parameter int unsigned PWR_W      = 16,
    parameter int unsigned CODE_W     = 10,
    parameter int unsigned AVG_LOG2   = 2,
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned PTS_W      = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  tuner_phy_detect_if_state_e mode_i,
    input  logic [PWR_W-1:0]           thresh_i,
    input  logic [PTS_W-1:0]           max_pts_i,
    input  logic                       pwr_valid_i,
    input  logic [PWR_W-1:0]           pwr_i,
    input  logic [CODE_W-1:0]          code_i,
    input  logic                       ack_i,
    output logic [2:0]                 state_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       found_o,
    output logic [PWR_W-1:0]           peak_pwr_o,
    output logic [CODE_W-1:0]          peak_code_o
);

    localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    tuner_phy_detect_state_e    state_q, state_d;
    tuner_phy_detect_if_state_e mode_q, mode_d;
    logic [PWR_W-1:0]  thresh_q, thresh_d;
    logic [PTS_W-1:0]  max_pts_q, max_pts_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [PTS_W-1:0]  pts_q, pts_d;
    logic [PWR_W-1:0]  max_q, max_d;
    logic [CODE_W-1:0] max_code_q, max_code_d;
    logic [PWR_W-1:0]  min_q, min_d;
    logic              armed_q, armed_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              found_q, found_d;
    logic [PWR_W-1:0]  peak_pwr_q, peak_pwr_d;
    logic [CODE_W-1:0] peak_code_q, peak_code_d;

    logic              avg_clr;
    logic              avg_valid;
    logic [PWR_W-1:0]  avg;
    logic [CODE_W-1:0] avg_code;

    logic [PWR_W-1:0]  pt_max;
    logic [CODE_W-1:0] pt_max_code;
    logic [PWR_W-1:0]  pt_min;
    logic              pt_armed;
    logic              pt_peak;
    logic [PTS_W-1:0]  pt_cnt;
    logic              pt_limit;

    assign avg_clr = abort_i || (state_q != DETECT_ACTIVE);

    tuner_phy_pwr_avg #(
        .PWR_W    (PWR_W),
        .CODE_W   (CODE_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_pwr_avg (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (avg_clr),
        .valid_i     (pwr_valid_i),
        .pwr_i       (pwr_i),
        .code_i      (code_i),
        .avg_valid_o (avg_valid),
        .avg_o       (avg),
        .avg_code_o  (avg_code)
    );

    // Per-point tracking: strict max keeps the earliest code on ties; arming sees updated min/max
    always_comb begin
        pt_max      = max_q;
        pt_max_code = max_code_q;
        pt_min      = min_q;
        if (avg > max_q) begin
            pt_max      = avg;
            pt_max_code = avg_code;
        end
        if (avg < min_q) begin
            pt_min = avg;
        end
        pt_armed = armed_q || ((pt_max - pt_min) >= thresh_q);
        pt_peak  = pt_armed && ((pt_max - avg) >= thresh_q);
        pt_cnt   = pts_q + PTS_W'(1);
        pt_limit = (pt_cnt == max_pts_q);
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        thresh_d    = thresh_q;
        max_pts_d   = max_pts_q;
        settle_d    = settle_q;
        pts_d       = pts_q;
        max_d       = max_q;
        max_code_d  = max_code_q;
        min_d       = min_q;
        armed_d     = armed_q;
        found_d     = found_q;
        peak_pwr_d  = peak_pwr_q;
        peak_code_d = peak_code_q;

        if (abort_i) begin
            state_d = DETECT_IDLE;
        end else begin
            unique case (state_q)
                DETECT_IDLE: begin
                    if (start_i) begin
                        state_d     = DETECT_WAIT;
                        mode_d      = mode_i;
                        thresh_d    = thresh_i;
                        max_pts_d   = max_pts_i;
                        settle_d    = '0;
                        pts_d       = '0;
                        max_d       = '0;
                        max_code_d  = '0;
                        min_d       = '1;
                        armed_d     = 1'b0;
                        found_d     = 1'b0;
                        peak_pwr_d  = '0;
                        peak_code_d = '0;
                    end
                end
                DETECT_WAIT: begin
                    settle_d = settle_q + SET_W'(1);
                    if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
                        state_d = DETECT_ACTIVE;
                    end
                end
                DETECT_ACTIVE: begin
                    if (avg_valid) begin
                        if (mode_q == PWR_READ) begin
                            state_d     = DETECT_DONE;
                            found_d     = 1'b1;
                            peak_pwr_d  = avg;
                            peak_code_d = avg_code;
                        end else begin
                            max_d      = pt_max;
                            max_code_d = pt_max_code;
                            min_d      = pt_min;
                            armed_d    = pt_armed;
                            pts_d      = pt_cnt;
                            if (pt_peak || pt_limit) begin
                                state_d     = DETECT_DONE;
                                found_d     = pt_peak;
                                peak_pwr_d  = pt_max;
                                peak_code_d = pt_max_code;
                            end
                        end
                    end
                end
                DETECT_DONE: begin
                    if (ack_i) begin
                        state_d = DETECT_IDLE;
                    end
                end
                default: state_d = DETECT_IDLE;
            endcase
        end

        busy_d = (state_d != DETECT_IDLE);
        done_d = (state_d == DETECT_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DETECT_IDLE;
            mode_q      <= PWR_READ;
            thresh_q    <= '0;
            max_pts_q   <= '0;
            settle_q    <= '0;
            pts_q       <= '0;
            max_q       <= '0;
            max_code_q  <= '0;
            min_q       <= '0;
            armed_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            found_q     <= 1'b0;
            peak_pwr_q  <= '0;
            peak_code_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            thresh_q    <= thresh_d;
            max_pts_q   <= max_pts_d;
            settle_q    <= settle_d;
            pts_q       <= pts_d;
            max_q       <= max_d;
            max_code_q  <= max_code_d;
            min_q       <= min_d;
            armed_q     <= armed_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            found_q     <= found_d;
            peak_pwr_q  <= peak_pwr_d;
            peak_code_q <= peak_code_d;
        end
    end

    assign state_o     = state_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign found_o     = found_q;
    assign peak_pwr_o  = peak_pwr_q;
    assign peak_code_o = peak_code_q;

endmodule
